// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_ctrl
// Brief    : Debug sequencer that freezes operand reads, walks every register
//            on the register file's debug read port and streams each value
//            out MSB-first as bytes over a valid/ready interface (UART TX).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   REG_COUNT  : registers dumped, indices 0..REG_COUNT-1 (1..32)
//   DATA_WIDTH : register width, multiple of 8
//   ADDR_WIDTH : debug read address width
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : one-cycle dump request, honoured only while idle
//   rd_data    : register file debug read data
//   tx_ready   : byte sink accepts tx_data this cycle
//   debug_on   : selects the register file debug read path
//   stop_debug : freezes normal operand reads during the dump
//   rd_addr    : debug read address
//   tx_data    : byte to transmit
//   tx_valid   : tx_data is valid
//   busy       : dump in progress
//   done       : one-cycle pulse after the last byte is accepted
// Build option
//   DUMP_CHECKSUM_EN : when defined, one extra byte (XOR of every dumped
//                      byte) is sent after the last register.
// ============================================================================
module regfile_dump_ctrl #(
    parameter int REG_COUNT  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  tx_ready,
    output logic                  debug_on,
    output logic                  stop_debug,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BYTES = DATA_WIDTH / 8;
    // Keep the counter at least one bit wide so 8-bit registers still build.
    localparam int c_CNT_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

    localparam logic [c_CNT_W-1:0]    c_CNT_LOAD = c_CNT_W'(c_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FREEZE = 4'd1,
        S_ADDR   = 4'd2,
        S_WAIT   = 4'd3,
        S_LOAD   = 4'd4,
        S_SEND   = 4'd5,
        S_NEXT   = 4'd6,
`ifdef DUMP_CHECKSUM_EN
        S_CSUM   = 4'd7,
`endif
        S_FIN    = 4'd8
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_index;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0]      r_byte_cnt;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]              r_csum;
`endif

    logic                    w_xfer;
    logic [DATA_WIDTH-1:0]   w_shift_next;

    // A byte leaves the block whenever the presented byte is taken.
    always_comb begin
        w_xfer       = tx_valid & tx_ready;
        w_shift_next = r_shift << 8;
    end

    // ------------------------------------------------------------------------
    // Sequencer. All outputs are registered here and are updated together
    // with the state so that each output already matches the state it
    // belongs to on the first cycle of that state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_csum     <= '0;
`endif
            debug_on   <= 1'b0;
            stop_debug <= 1'b0;
            rd_addr    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the entry into FIN raises it.
            done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FREEZE;
                        busy       <= 1'b1;
                        // Freeze one cycle ahead of switching the read path
                        // so the last normal operand read is held.
                        stop_debug <= 1'b1;
                    end
                end

                S_FREEZE: begin
`ifdef DUMP_CHECKSUM_EN
                    r_csum   <= '0;
`endif
                    r_state  <= S_ADDR;
                    debug_on <= 1'b1;
                    rd_addr  <= r_index;
                end

                // The register file captures the address on the falling edge
                // in ADDR; WAIT gives one more cycle of margin before LOAD
                // samples rd_data (two rising edges after rd_addr changes).
                S_ADDR: begin
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    r_state <= S_LOAD;
                end

                S_LOAD: begin
                    r_shift    <= rd_data;
                    r_byte_cnt <= c_CNT_LOAD;
                    tx_data    <= rd_data[DATA_WIDTH-1 -: 8];
                    tx_valid   <= 1'b1;
                    r_state    <= S_SEND;
                end

                // tx_data/tx_valid only change on an accepted transfer, so
                // they hold steady for as long as the sink stalls.
                S_SEND: begin
                    if (w_xfer) begin
`ifdef DUMP_CHECKSUM_EN
                        r_csum  <= r_csum ^ tx_data;
`endif
                        r_shift <= w_shift_next;
                        if (r_byte_cnt == '0) begin
                            tx_valid <= 1'b0;
                            r_state  <= S_NEXT;
                        end else begin
                            r_byte_cnt <= r_byte_cnt - c_CNT_W'(1);
                            tx_data    <= w_shift_next[DATA_WIDTH-1 -: 8];
                        end
                    end
                end

                S_NEXT: begin
                    if (r_index == c_LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                        r_state    <= S_CSUM;
                        tx_data    <= r_csum;
                        tx_valid   <= 1'b1;
`else
                        r_state    <= S_FIN;
                        done       <= 1'b1;
                        debug_on   <= 1'b0;
                        stop_debug <= 1'b0;
`endif
                    end else begin
                        // Index stops at the last register; it never wraps.
                        r_index <= r_index + ADDR_WIDTH'(1);
                        rd_addr <= r_index + ADDR_WIDTH'(1);
                        r_state <= S_ADDR;
                    end
                end

`ifdef DUMP_CHECKSUM_EN
                // Register file stays frozen while the trailing checksum
                // byte is sent; everything is released on entry to FIN.
                S_CSUM: begin
                    if (w_xfer) begin
                        tx_valid   <= 1'b0;
                        r_state    <= S_FIN;
                        done       <= 1'b1;
                        debug_on   <= 1'b0;
                        stop_debug <= 1'b0;
                    end
                end
`endif

                S_FIN: begin
                    r_index <= '0;
                    rd_addr <= '0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_index    <= '0;
                    rd_addr    <= '0;
                    debug_on   <= 1'b0;
                    stop_debug <= 1'b0;
                    tx_valid   <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
- Debug sequencer that owns the register file's debug read port and its freeze control.
- On a start request it freezes normal operand reads, walks register indices 0..REG_COUNT-1 on the debug port, and streams each 32-bit value as bytes, MSB first, over a valid/ready byte interface to the UART TX path.
- Sits between the debug unit and the register file.

Parameters:
REG_COUNT, 32, number of registers dumped, indices 0..REG_COUNT-1 (1..32)
DATA_WIDTH, 32, register width; must be a multiple of 8
ADDR_WIDTH, 5, width of the debug read address

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
rd_data  input  DATA_WIDTH  register file debug read data
tx_ready  input  1  byte sink can accept tx_data this cycle
debug_on  output  1  selects the register file's debug read path
stop_debug  output  1  freezes normal operand reads during the dump
rd_addr  output  ADDR_WIDTH  debug read address
tx_data  output  8  byte to transmit
tx_valid  output  1  tx_data is valid
busy  output  1  dump in progress
done  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; rd_addr 0; byte counter 0; shift register 0.
- States: IDLE, FREEZE, ADDR, WAIT, LOAD, SEND, NEXT, FIN.
- IDLE:
  - start=1 -> FREEZE.
  - busy=0, stop_debug=0, debug_on=0.
- FREEZE:
  - stop_debug=1 for one cycle before debug_on rises, so the last normal operand read is held.
  - -> ADDR.
- ADDR:
  - debug_on=1, rd_addr = current index.
  - -> WAIT.
  - The register file captures on the falling edge.
- WAIT:
  - One cycle of margin.
  - -> LOAD.
  - Read latency from rd_addr change to rd_data sampled: 2 rising edges.
- LOAD:
  - Shift register <= rd_data.
  - Byte counter <= DATA_WIDTH/8 - 1.
  - -> SEND.
- SEND:
  - tx_valid=1, tx_data = shift register [DATA_WIDTH-1 -: 8].
  - On tx_valid && tx_ready: shift left by 8.
    - If byte counter = 0 -> NEXT; else decrement the counter.
  - tx_data and tx_valid stay stable while tx_ready=0. tx_valid is never dropped without a transfer.
- NEXT:
  - If index = REG_COUNT-1 -> FIN; else index+1 -> ADDR.
  - The index never wraps.
- FIN:
  - done=1 for one cycle; debug_on=0; stop_debug=0.
  - Index <= 0.
  - -> IDLE.
- busy=1 in every state except IDLE.
- stop_debug=1 from FREEZE through NEXT.
- debug_on=1 from ADDR through NEXT.
- start while busy is ignored; no queueing.
- A write to the register file during the dump is allowed; the dump shows whatever value is sampled in LOAD.
- Reset mid-dump: immediate return to IDLE; all outputs 0, including a tx_valid in flight.
- Total transfers per dump: REG_COUNT*DATA_WIDTH/8 bytes (128 at defaults), plus the checksum byte when enabled.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - After the last register's bytes, state CSUM sends one extra byte = XOR of all dumped bytes, then -> FIN.
  - The XOR accumulator clears in FREEZE and accumulates on each accepted byte.
- Undefined: no CSUM state and no accumulator; NEXT goes directly to FIN.

Test Plan:
- Reset release, no start -> all outputs 0 and busy=0 for 20 cycles; drive rst low mid-SEND -> tx_valid, busy, debug_on and stop_debug fall immediately, no done.
- Register file loaded with reg k = 0x00000010+k, tx_ready=1, start pulse -> 128 bytes in order:
  - 00 00 00 10, 00 00 00 11, ... , 00 00 00 2F.
  - rd_addr steps 0..31.
  - done pulses once after byte 128; busy then 0.
- Throttle with tx_ready=0 for 5 cycles on byte 3 of reg 7 -> tx_data holds 0x00 and tx_valid stays 1; no byte is lost or duplicated.
- start pulsed again at byte 40 -> ignored; still exactly 128 bytes and one done.
- Check stop_debug and debug_on on start -> stop_debug rises one cycle before debug_on; both fall in FIN.
- DUMP_CHECKSUM_EN defined, reg 31 = 0x0000002A, all other registers 0 -> 129th byte = 0x2A; undefined -> exactly 128 bytes.
